// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state codes and majority-vote helper.
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_W = 8;
  localparam int SAMP_LO = 7;
  localparam int SAMP_MID = 8;
  localparam int SAMP_HI = 9;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP = 3'd4;
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte valid/ready stream plus per-frame error pulses.
interface uart_rx_if;
  import uart_pkg::*;
  logic [DATA_W-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic frame_err;
  logic overrun;
  logic parity_err;
  modport master (output rx_data, rx_valid, frame_err, overrun, parity_err, input rx_ready);
  modport slave (input rx_data, rx_valid, frame_err, overrun, parity_err, output rx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16x oversample tick generator with synchronous clear.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 40000000,
  parameter int BAUD = 115200
) (
  input  logic user_clock,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int DIV = (CLK_HZ + (OVERSAMPLE / 2) * BAUD) / (OVERSAMPLE * BAUD);
  localparam int W = ($clog2(DIV) > 5) ? $clog2(DIV) : 5;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge user_clock or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 receiver with holding register and error pulses.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 40000000,
  parameter int BAUD = 115200
) (
  input  logic user_clock,
  input  logic rst,
  input  logic usb_rs232_rxd,
  uart_rx_if.master rx
);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic [1:0] sync;
  logic line, tick, samp_en, dec, maj, hold, done, fe, pe, par_bad;
  logic [2:0] state, bit_cnt, samp;
  logic [3:0] os;
  logic [DATA_W-1:0] shreg;
  uart_baud_gen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_baud (
    .user_clock(user_clock), .rst(rst), .clr(state == ST_IDLE), .tick(tick)
  );
  assign line = sync[1];
  assign maj = maj3(samp);
  assign samp_en = tick && (os == 4'(SAMP_LO) || os == 4'(SAMP_MID) || os == 4'(SAMP_HI));
  // the stop bit is decided right after its last vote so the next start edge is never missed
  assign dec = tick && os == (state == ST_STOP ? 4'(SAMP_HI + 1) : 4'(OVERSAMPLE - 1));
  assign done = state == ST_STOP && !hold && dec && maj && !par_bad;
  always_ff @(posedge user_clock or negedge rst)
    if (!rst) begin
      sync <= 2'b11;
      state <= ST_IDLE;
      os <= '0;
      bit_cnt <= '0;
      samp <= '0;
      shreg <= '0;
      hold <= 1'b0;
      fe <= 1'b0;
      pe <= 1'b0;
    end else begin
      sync <= {sync[0], usb_rs232_rxd};
      fe <= 1'b0;
      pe <= 1'b0;
      os <= state == ST_IDLE ? '0 : os + 4'(tick);
      if (samp_en) samp <= {samp[1:0], line};
      case (state)
        ST_IDLE: if (!line) state <= ST_START;
        ST_START: if (dec) state <= maj ? ST_IDLE : ST_DATA;
        ST_DATA: if (dec) begin
          shreg <= {maj, shreg[DATA_W-1:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= PAR_EN ? ST_PARITY : ST_STOP;
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (dec) state <= ST_STOP;
`endif
        ST_STOP: if (hold) begin
          if (line) begin
            hold <= 1'b0;
            state <= ST_IDLE;
          end
        end else if (dec) begin
          if (maj) begin
            state <= ST_IDLE;
            pe <= par_bad;
          end else begin
            hold <= 1'b1;
            fe <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge user_clock or negedge rst)
    if (!rst) par_bad <= 1'b0;
    else if (state == ST_PARITY && dec) par_bad <= maj ^ (^shreg);
`else
  assign par_bad = 1'b0;
`endif
  assign rx.frame_err = fe;
  assign rx.parity_err = pe;
  always_ff @(posedge user_clock or negedge rst)
    if (!rst) begin
      rx.rx_data <= '0;
      rx.rx_valid <= 1'b0;
      rx.overrun <= 1'b0;
    end else begin
      rx.overrun <= done && rx.rx_valid && !rx.rx_ready;
      if (done && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data <= shreg;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a byte-level expectation model.
module tb_uart_rx;
  import uart_pkg::*;
  localparam int CLK_HZ = 40000000;
  localparam int BAUD = 115200;
  localparam int BIT = CLK_HZ / BAUD;
  localparam int OS_T = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  logic user_clock = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;
  uart_rx_if rx ();
  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .user_clock(user_clock), .rst(rst), .usb_rs232_rxd(rxd), .rx(rx)
  );
  always #5 user_clock = ~user_clock;
  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] got[$];
  int vld_rise = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  logic vld_q = 1'b0;
  always @(negedge user_clock) begin
    if (rx.rx_valid && rx.rx_ready) got.push_back(rx.rx_data);
    vld_rise <= vld_rise + int'(rx.rx_valid && !vld_q);
    vld_q <= rx.rx_valid;
    fe_cnt <= fe_cnt + int'(rx.frame_err);
    ov_cnt <= ov_cnt + int'(rx.overrun);
    pe_cnt <= pe_cnt + int'(rx.parity_err);
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge user_clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one serial frame at the true bit rate; par_flip inverts the even-parity bit
  task automatic send(input logic [7:0] b, input logic stop, input logic par_flip);
    rxd = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ par_flip;
    cyc(BIT);
`endif
    rxd = stop;
    cyc(BIT);
    rxd = 1'b1;
    cyc(BIT);
  endtask
  int g0, v0, f0, o0, p0;
  logic [7:0] exp_q[$];
  int exp_fe, exp_pe;
  logic [7:0] rb;
  logic bad_stop, bad_par;
  initial begin
    rx.rx_ready = 1'b1;
    cyc(5);
    chk("rst_valid", rx.rx_valid, 0);
    chk("rst_data", rx.rx_data, 0);
    chk("rst_errs", {rx.frame_err, rx.overrun, rx.parity_err}, 0);
    chk("rst_state", dut.state, ST_IDLE);
    rst = 1'b1;
    cyc(BIT);
    g0 = got.size(); v0 = vld_rise;
    send(8'h42, 1'b1, 1'b0);
    chk("b42_count", got.size() - g0, 1);
    chk("b42_data", got[g0], 8'h42);
    chk("b42_pulses", vld_rise - v0, 1);
    chk("b42_errs", fe_cnt + ov_cnt + pe_cnt, 0);
    g0 = got.size(); v0 = vld_rise; f0 = fe_cnt;
    rxd = 1'b0;
    cyc(2 * OS_T);
    rxd = 1'b1;
    cyc(4 * OS_T);
    chk("glitch_start", dut.state, ST_START);
    cyc(10 * OS_T + 6);
    chk("glitch_idle", dut.state, ST_IDLE);
    cyc(BIT);
    chk("glitch_novalid", vld_rise - v0, 0);
    chk("glitch_nofe", fe_cnt - f0, 0);
    g0 = got.size(); o0 = ov_cnt;
    rx.rx_ready = 1'b0;
    send(8'hA5, 1'b1, 1'b0);
    chk("ovr_first_valid", rx.rx_valid, 1);
    chk("ovr_first_data", rx.rx_data, 8'hA5);
    send(8'h3C, 1'b1, 1'b0);
    chk("ovr_kept_data", rx.rx_data, 8'hA5);
    chk("ovr_pulse", ov_cnt - o0, 1);
    rx.rx_ready = 1'b1;
    cyc(3);
    chk("ovr_drained", rx.rx_valid, 0);
    chk("ovr_consumed", got.size() - g0, 1);
    chk("ovr_consumed_data", got[g0], 8'hA5);
    g0 = got.size(); v0 = vld_rise; f0 = fe_cnt;
    send(8'h55, 1'b0, 1'b0);
    chk("fe_pulse", fe_cnt - f0, 1);
    chk("fe_novalid", vld_rise - v0, 0);
    send(8'h0F, 1'b1, 1'b0);
    chk("fe_next_count", got.size() - g0, 1);
    chk("fe_next_data", got[g0], 8'h0F);
    g0 = got.size(); f0 = fe_cnt;
    rxd = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b1;
      cyc(BIT);
    end
    rst = 1'b0;
    cyc(3);
    chk("mid_rst_state", dut.state, ST_IDLE);
    chk("mid_rst_data", rx.rx_data, 0);
    chk("mid_rst_valid", rx.rx_valid, 0);
    rst = 1'b1;
    cyc(2 * BIT);
    send(8'h81, 1'b1, 1'b0);
    chk("mid_rst_count", got.size() - g0, 1);
    chk("mid_rst_byte", got[g0], 8'h81);
    chk("mid_rst_nofe", fe_cnt - f0, 0);
`ifdef UART_RX_PARITY_EN
    g0 = got.size(); v0 = vld_rise; p0 = pe_cnt;
    send(8'h07, 1'b1, 1'b1);
    chk("par_bad_pulse", pe_cnt - p0, 1);
    chk("par_bad_novalid", vld_rise - v0, 0);
    send(8'h07, 1'b1, 1'b0);
    chk("par_ok_count", got.size() - g0, 1);
    chk("par_ok_data", got[g0], 8'h07);
`else
    chk("par_tied_zero", pe_cnt, 0);
`endif
    g0 = got.size(); f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
    exp_fe = 0; exp_pe = 0;
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      bad_stop = $urandom_range(0, 3) == 0;
`ifdef UART_RX_PARITY_EN
      bad_par = $urandom_range(0, 3) == 0;
`else
      bad_par = 1'b0;
`endif
      if (bad_stop) exp_fe++;
      else if (bad_par) exp_pe++;
      else exp_q.push_back(rb);
      send(rb, !bad_stop, bad_par);
    end
    chk("rnd_count", got.size() - g0, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) chk($sformatf("rnd_byte%0d", k), got[g0 + k], exp_q[k]);
    chk("rnd_fe", fe_cnt - f0, exp_fe);
    chk("rnd_pe", pe_cnt - p0, exp_pe);
    chk("rnd_ovr", ov_cnt - o0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
